pipe_stage_reg: RTL and testbench

- Parametrised successor to the fixed EX/MEM-style pipeline latch.
- Registers one pipeline stage's control bundle and data bundle between two stages, using a valid/ready handshake, so stalls no longer need a global enable.
- Optional 2-entry skid buffer makes upstream ready a pure register output, which breaks the backward stall path.
- Synchronous flush kills in-flight contents on branch/jump redirect; control bits are forced to zero on every bubble so no spurious MemWrite/RegWrite escapes.

---
 rtl/pipe_pkg.sv | 23 ++
 rtl/pipe_skid_slot.sv | 34 +++
 rtl/pipe_stage_reg.sv | 135 +++++++++++++
 tb/tb_pipe_stage_reg.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage register: control-bit positions,
// stage-state encoding and default bundle width.
package pipe_pkg;

    localparam int CTRL_W_DEF = 9;

    // Control bundle bit positions (WB bits high, M bits below, bit 0 spare)
    localparam int WB_REGWRITE = 8;
    localparam int WB_MEMTOREG = 7;
    localparam int M_MEMREAD   = 6;
    localparam int M_MEMWRITE  = 5;
    localparam int M_BRANCH    = 4;
    localparam int M_BNE       = 3;
    localparam int M_JUMP      = 2;
    localparam int M_JR        = 1;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } stage_state_t;

endpackage

// File: rtl/pipe_skid_slot.sv
// One pipeline entry: valid + control + data with load and clear.
// Clearing a slot inserts a bubble: control goes to zero, data is left stable.
module pipe_skid_slot #(
    parameter int CTRL_W = 9,
    parameter int DATA_W = 128
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              load,
    input  logic              clear,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              valid,
    output logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] data
);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            valid <= 1'b0;
            ctrl  <= '0;
            data  <= '0;
        end else if (clear) begin
            // NOTE: ctrl is zeroed in the same register write as valid, never gated on the output path.
            valid <= 1'b0;
            ctrl  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            ctrl  <= in_ctrl;
            data  <= in_data;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with optional 2-entry skid buffer
// (registered In_Ready) and synchronous flush.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int DATA_W = 128,
    parameter bit SKID   = 1'b1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Flush,
    input  logic              In_Valid,
    output logic              In_Ready,
    input  logic [CTRL_W-1:0] In_Ctrl,
    input  logic [DATA_W-1:0] In_Data,
    output logic              Out_Valid,
    input  logic              Out_Ready,
    output logic [CTRL_W-1:0] Out_Ctrl,
    output logic [DATA_W-1:0] Out_Data,
    output logic [1:0]        Occupancy
);

    stage_state_t      state, next_state;
    logic              rdy_q;
    logic              accept, consume;
    logic              main_load, main_clr, main_from_skid;
    logic              skid_load, skid_clr;
    logic              main_valid, skid_valid;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_in_ctrl;
    logic [DATA_W-1:0] main_data, skid_data, main_in_data;

    // Without the skid slot, rdy_q only holds In_Ready low through reset.
    assign In_Ready = SKID ? rdy_q : (rdy_q & (~main_valid | Out_Ready));
    assign accept   = In_Valid & In_Ready;
    assign consume  = main_valid & Out_Ready;

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        next_state     = state;
        main_load      = 1'b0;
        main_clr       = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clr       = 1'b0;
        if (Flush) begin
            next_state = ST_EMPTY;
            main_clr   = 1'b1;
            skid_clr   = 1'b1;
        end else begin
            unique case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        next_state = ST_ONE;
                        main_load  = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (accept && consume) begin
                        main_load = 1'b1;
                    end else if (accept && SKID) begin
                        next_state = ST_TWO;
                        skid_load  = 1'b1;
                    end else if (consume) begin
                        next_state = ST_EMPTY;
                        main_clr   = 1'b1;
                    end
                end
                ST_TWO: begin
                    if (consume) begin
                        next_state     = ST_ONE;
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                        skid_clr       = 1'b1;
                    end
                end
                default: next_state = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
            state <= ST_EMPTY;
            rdy_q <= 1'b0;
        end else begin
            state <= next_state;
            rdy_q <= SKID ? (next_state != ST_TWO) : 1'b1;
        end
    end

    assign main_in_ctrl = main_from_skid ? skid_ctrl : In_Ctrl;
    assign main_in_data = main_from_skid ? skid_data : In_Data;

    pipe_skid_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
        .Clk     (Clk),
        .Reset   (Reset),
        .load    (main_load),
        .clear   (main_clr),
        .in_ctrl (main_in_ctrl),
        .in_data (main_in_data),
        .valid   (main_valid),
        .ctrl    (main_ctrl),
        .data    (main_data)
    );

    generate
        if (SKID) begin : g_skid
            pipe_skid_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
                .Clk     (Clk),
                .Reset   (Reset),
                .load    (skid_load),
                .clear   (skid_clr),
                .in_ctrl (In_Ctrl),
                .in_data (In_Data),
                .valid   (skid_valid),
                .ctrl    (skid_ctrl),
                .data    (skid_data)
            );
        end else begin : g_no_skid
            logic unused_skid;
            assign unused_skid = skid_load | skid_clr;
            assign skid_valid  = 1'b0;
            assign skid_ctrl   = '0;
            assign skid_data   = '0;
        end
    endgenerate

    assign Out_Valid = main_valid;
    assign Out_Ctrl  = main_ctrl;
    assign Out_Data  = main_data;
    assign Occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Drives a SKID=1 and a SKID=0 instance side by side against a queue-based
// reference model (a FIFO of capacity 2 or 1 with the documented ready rules).
module tb_pipe_stage_reg;

    logic Clk = 1'b0;
    logic Reset;
    always #5 Clk = ~Clk;

    logic         v1, f1, or1, ir1, ov1;
    logic [8:0]   c1, oc1;
    logic [127:0] d1, od1;
    logic [1:0]   occ1;
    logic         v0, f0, or0, ir0, ov0;
    logic [8:0]   c0, oc0;
    logic [127:0] d0, od0;
    logic [1:0]   occ0;

    pipe_stage_reg #(.CTRL_W(9), .DATA_W(128), .SKID(1'b1)) dut1 (
        .Clk(Clk), .Reset(Reset), .Flush(f1), .In_Valid(v1), .In_Ready(ir1),
        .In_Ctrl(c1), .In_Data(d1), .Out_Valid(ov1), .Out_Ready(or1),
        .Out_Ctrl(oc1), .Out_Data(od1), .Occupancy(occ1));

    pipe_stage_reg #(.CTRL_W(9), .DATA_W(128), .SKID(1'b0)) dut0 (
        .Clk(Clk), .Reset(Reset), .Flush(f0), .In_Valid(v0), .In_Ready(ir0),
        .In_Ctrl(c0), .In_Data(d0), .Out_Valid(ov0), .Out_Ready(or0),
        .Out_Ctrl(oc0), .Out_Data(od0), .Occupancy(occ0));

    typedef struct {
        logic [8:0]   ctrl;
        logic [127:0] data;
    } ent_t;

    ent_t         q1[$], q0[$];
    logic [127:0] emitted1[$];
    bit           rdy1, en0, acc1, acc0;
    int           errors = 0;
    int           checks = 0;

    task automatic model_reset();
        q1.delete(); q0.delete();
        rdy1 = 1'b0; en0 = 1'b0;
    endtask

    // Advance one clock edge and update the model from pre-edge inputs.
    task automatic step();
        bit   c1_ev, c0_ev;
        ent_t e;
        acc1  = v1 && rdy1;
        c1_ev = (q1.size() > 0) && or1;
        acc0  = v0 && en0 && ((q0.size() == 0) || or0);
        c0_ev = (q0.size() > 0) && or0;
        if (c1_ev) emitted1.push_back(od1);
        @(posedge Clk);
        if (c1_ev) void'(q1.pop_front());
        if (f1) q1.delete();
        else if (acc1) begin e.ctrl = c1; e.data = d1; q1.push_back(e); end
        rdy1 = (q1.size() < 2);
        if (c0_ev) void'(q0.pop_front());
        if (f0) q0.delete();
        else if (acc0) begin e.ctrl = c0; e.data = d0; q0.push_back(e); end
        en0 = 1'b1;
        #1;
    endtask

    function automatic logic [8:0] exp_ctrl1();
        return (q1.size() > 0) ? q1[0].ctrl : 9'h000;
    endfunction
    function automatic logic [8:0] exp_ctrl0();
        return (q0.size() > 0) ? q0[0].ctrl : 9'h000;
    endfunction

    task automatic test_reset();
        #3;
        checks++; if (ir1 !== 1'b0 || ir0 !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b/%b want 0/0", ir1, ir0); end
        checks++; if (ov1 !== 1'b0 || oc1 !== 9'h0 || od1 !== '0 || occ1 !== 2'd0) begin errors++; $display("FAIL reset_outputs: valid=%b ctrl=%h data=%h occ=%0d want all zero", ov1, oc1, od1, occ1); end
        @(negedge Clk); Reset = 1'b1;
        step();
        checks++; if (ir1 !== 1'b1 || ir0 !== 1'b1) begin errors++; $display("FAIL ready_after_release: got %b/%b want 1/1", ir1, ir0); end
        // fill dut1 to two entries, dut0 to one
        or1 = 1'b0; or0 = 1'b0; v1 = 1'b1; v0 = 1'b1;
        c1 = 9'h155; d1 = 128'd11; c0 = 9'h0AA; d0 = 128'd21; step();
        c1 = 9'h156; d1 = 128'd12; step();
        v1 = 1'b0; v0 = 1'b0;
        checks++; if (occ1 !== 2'd2 || ir1 !== 1'b0) begin errors++; $display("FAIL fill_two: occ=%0d ready=%b want 2/0", occ1, ir1); end
        Reset = 1'b0; model_reset(); #1;
        checks++; if (ov1 !== 1'b0 || oc1 !== 9'h0 || ir1 !== 1'b0 || occ1 !== 2'd0) begin errors++; $display("FAIL async_reset_skid: valid=%b ctrl=%h ready=%b occ=%0d want 0", ov1, oc1, ir1, occ1); end
        checks++; if (ov0 !== 1'b0 || oc0 !== 9'h0 || ir0 !== 1'b0 || occ0 !== 2'd0) begin errors++; $display("FAIL async_reset_single: valid=%b ctrl=%h ready=%b occ=%0d want 0", ov0, oc0, ir0, occ0); end
        @(negedge Clk); Reset = 1'b1; #1;
        checks++; if (ir1 !== 1'b0) begin errors++; $display("FAIL ready_before_edge: got %b want 0", ir1); end
        or1 = 1'b1; or0 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (ir1 !== 1'b1 || occ1 !== 2'd0 || ov1 !== 1'b0 || ov0 !== 1'b0) begin errors++; $display("FAIL post_reset_empty: ready=%b occ=%0d valid=%b/%b want 1/0/0/0", ir1, occ1, ov1, ov0); end
        end
    endtask

    task automatic test_stream();
        v1 = 1'b1; v0 = 1'b1; or1 = 1'b1; or0 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            c1 = 9'h1A5; d1 = 128'(i); c0 = 9'h1A5; d0 = 128'(i);
            step();
            checks++; if (ov1 !== 1'b1 || oc1 !== 9'h1A5 || od1 !== 128'(i) || occ1 !== 2'd1) begin errors++; $display("FAIL stream_skid[%0d]: valid=%b ctrl=%h data=%0d occ=%0d want 1/1a5/%0d/1", i, ov1, oc1, od1, occ1, i); end
            checks++; if (ov0 !== 1'b1 || oc0 !== 9'h1A5 || od0 !== 128'(i) || occ0 !== 2'd1) begin errors++; $display("FAIL stream_single[%0d]: valid=%b ctrl=%h data=%0d occ=%0d want 1/1a5/%0d/1", i, ov0, oc0, od0, occ0, i); end
        end
        v1 = 1'b0; v0 = 1'b0;
        step();
        checks++; if (ov1 !== 1'b0 || oc1 !== 9'h0 || ov0 !== 1'b0 || oc0 !== 9'h0) begin errors++; $display("FAIL stream_drain: valid=%b/%b ctrl=%h/%h want 0", ov1, ov0, oc1, oc0); end
    endtask

    task automatic test_skid_stall();
        int k = 0;
        emitted1.delete();
        or1 = 1'b0; v1 = 1'b1;
        for (int cyc = 0; cyc < 3; cyc++) begin
            c1 = 9'h100 | 9'(k); d1 = 128'(100 + k);
            step();
            if (acc1) k++;
            checks++; if (occ1 !== ((cyc == 0) ? 2'd1 : 2'd2)) begin errors++; $display("FAIL stall_occ[%0d]: got %0d want %0d", cyc, occ1, (cyc == 0) ? 1 : 2); end
            if (cyc >= 1) begin
                checks++; if (ir1 !== 1'b0) begin errors++; $display("FAIL stall_ready[%0d]: got %b want 0", cyc, ir1); end
            end
        end
        or1 = 1'b1;
        for (int cyc = 0; cyc < 12 && emitted1.size() < 4; cyc++) begin
            v1 = (k < 4);
            c1 = 9'h100 | 9'(k); d1 = 128'(100 + k);
            step();
            if (acc1) k++;
            checks++; if (ov1 !== (q1.size() > 0) || oc1 !== exp_ctrl1() || (ov1 && od1 !== q1[0].data)) begin errors++; $display("FAIL drain_out[%0d]: valid=%b ctrl=%h data=%0d", cyc, ov1, oc1, od1); end
        end
        v1 = 1'b0;
        checks++; if (emitted1.size() != 4) begin errors++; $display("FAIL drain_count: got %0d want 4", emitted1.size()); end
        for (int i = 0; i < emitted1.size() && i < 4; i++) begin
            checks++; if (emitted1[i] !== 128'(100 + i)) begin errors++; $display("FAIL drain_order[%0d]: got %0d want %0d", i, emitted1[i], 100 + i); end
        end
    endtask

    task automatic test_flush_full();
        or1 = 1'b0; v1 = 1'b1;
        c1 = 9'h0F0; d1 = 128'd200; step();
        c1 = 9'h0F1; d1 = 128'd201; step();
        checks++; if (occ1 !== 2'd2) begin errors++; $display("FAIL flush_prefill: occ=%0d want 2", occ1); end
        f1 = 1'b1; c1 = 9'h1FF; d1 = 128'hDEAD;
        step();
        f1 = 1'b0; v1 = 1'b0;
        checks++; if (ov1 !== 1'b0 || oc1 !== 9'h000 || occ1 !== 2'd0 || ir1 !== 1'b1) begin errors++; $display("FAIL flush_full: valid=%b ctrl=%h occ=%0d ready=%b want 0/000/0/1", ov1, oc1, occ1, ir1); end
        checks++; if (od1 !== 128'd200) begin errors++; $display("FAIL flush_data_hold: got %0d want 200", od1); end
        or1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (ov1 !== 1'b0 || oc1 !== 9'h0) begin errors++; $display("FAIL flush_no_leak[%0d]: valid=%b ctrl=%h want 0/0", i, ov1, oc1); end
        end
    endtask

    task automatic test_flush_consume();
        int n;
        or1 = 1'b0; v1 = 1'b1; c1 = 9'h1FF; d1 = 128'd300;
        step();
        v1 = 1'b0; or1 = 1'b1; f1 = 1'b1; #1;
        checks++; if (ov1 !== 1'b1 || od1 !== 128'd300) begin errors++; $display("FAIL flush_consume_pre: valid=%b data=%0d want 1/300", ov1, od1); end
        n = emitted1.size();
        step();
        f1 = 1'b0;
        checks++; if (emitted1.size() != n + 1 || emitted1[$] !== 128'd300) begin errors++; $display("FAIL flush_consume_count: got %0d entries want %0d", emitted1.size(), n + 1); end
        checks++; if (ov1 !== 1'b0 || occ1 !== 2'd0 || ir1 !== 1'b1 || oc1 !== 9'h0) begin errors++; $display("FAIL flush_consume_post: valid=%b occ=%0d ready=%b ctrl=%h want 0/0/1/0", ov1, occ1, ir1, oc1); end
    endtask

    task automatic test_random();
        acc1 = 1'b1; acc0 = 1'b1;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            if (!(v0 && !acc0)) begin
                v0 = 1'($urandom_range(0, 1)); c0 = 9'($urandom_range(1, 511));
                d0 = {$urandom, $urandom, $urandom, $urandom};
            end
            if (!(v1 && !acc1)) begin
                v1 = 1'($urandom_range(0, 1)); c1 = 9'($urandom_range(1, 511));
                d1 = {$urandom, $urandom, $urandom, $urandom};
            end
            or0 = 1'($urandom_range(0, 1)); or1 = 1'($urandom_range(0, 1));
            f0 = ($urandom_range(0, 31) == 0); f1 = ($urandom_range(0, 31) == 0);
            #1;
            checks++; if (ir0 !== (!ov0 | or0) || ir0 !== (en0 && (q0.size() == 0 || or0))) begin errors++; $display("FAIL rand_ready_single[%0d]: got %b valid=%b out_ready=%b", cyc, ir0, ov0, or0); end
            checks++; if (ir1 !== rdy1) begin errors++; $display("FAIL rand_ready_skid[%0d]: got %b want %b", cyc, ir1, rdy1); end
            step();
            checks++; if (ov0 !== (q0.size() > 0) || oc0 !== exp_ctrl0() || occ0 !== 2'(q0.size()) || (ov0 && od0 !== q0[0].data)) begin errors++; $display("FAIL rand_single[%0d]: valid=%b ctrl=%h occ=%0d data=%h", cyc, ov0, oc0, occ0, od0); end
            checks++; if (ov1 !== (q1.size() > 0) || oc1 !== exp_ctrl1() || occ1 !== 2'(q1.size()) || (ov1 && od1 !== q1[0].data)) begin errors++; $display("FAIL rand_skid[%0d]: valid=%b ctrl=%h occ=%0d data=%h", cyc, ov1, oc1, occ1, od1); end
        end
        f0 = 1'b0; f1 = 1'b0; v0 = 1'b0; v1 = 1'b0;
    endtask

    initial begin
        Reset = 1'b0;
        v1 = 1'b0; f1 = 1'b0; or1 = 1'b0; c1 = '0; d1 = '0;
        v0 = 1'b0; f0 = 1'b0; or0 = 1'b0; c0 = '0; d0 = '0;
        model_reset();
        test_reset();
        test_stream();
        test_skid_stall();
        test_flush_full();
        test_flush_consume();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
